// File: rtl/alu_share_sequencer.sv
// alu_share_sequencer: shares one combinational ALU between two requesters with round-robin arbitration.
// Define ALU_FLAGS_EN to add the registered rsp_zero/rsp_neg result flags.
module alu_share_sequencer #(
  parameter int WIDTH = 8,
  parameter int OP_W  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             req1_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  input  logic             rsp_ready,
`ifdef ALU_FLAGS_EN
  output logic             rsp_zero,
  output logic             rsp_neg,
`endif
  output logic             busy
);
  // state | meaning
  // IDLE  | arbitrate, accept at most one request
  // EXEC  | operands stable on alu_*, result captured at end of cycle
  // RESP  | response presented until rsp_ready
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   last_id;
  logic   id;
  logic   accept;

  always_comb begin
    state_nxt  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state)
      IDLE: begin
        // last_id==1 means requester 0 holds priority on a tie
        req0_ready = !rst && req0_valid && (!req1_valid || last_id);
        req1_ready = !rst && req1_valid && (!req0_valid || !last_id);
        if (req0_ready || req1_ready) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign accept    = req0_ready | req1_ready;
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      id       <= 1'b0;
      last_id  <= 1'b1;
      rsp_data <= '0;
      rsp_id   <= 1'b0;
`ifdef ALU_FLAGS_EN
      rsp_zero <= 1'b0;
      rsp_neg  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        id      <= req1_ready;
        last_id <= req1_ready;
        alu_a   <= req1_ready ? req1_a  : req0_a;
        alu_b   <= req1_ready ? req1_b  : req0_b;
        alu_op  <= req1_ready ? req1_op : req0_op;
      end
      if (state == EXEC) begin
        rsp_data <= alu_result;
        rsp_id   <= id;
`ifdef ALU_FLAGS_EN
        rsp_zero <= (alu_result == '0);
        rsp_neg  <= alu_result[WIDTH-1];
`endif
      end
    end
  end
endmodule
